// File: rtl/hdlc_rx_line_checker.sv
// HDLC Rx line checker: re-decodes flags, aborts and frame length per channel; flags Rx disagreements as error pulses.
// Latency: error pulse registers two edges after the last matching bit; sticky bits and the counter follow one edge later.
// No backpressure: every input is sampled each Clk. The FLAG_SPUR check exists only when HDLC_CHK_SPURIOUS_EN is defined.
module hdlc_rx_line_checker #(
    parameter int NUM_CH          = 1,
    parameter int CNT_W           = 16,
    parameter int MAX_FRAME_BYTES = 128
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NUM_CH-1:0]     Rx,
    input  logic [NUM_CH-1:0]     Rx_FlagDetect,
    input  logic [NUM_CH-1:0]     Rx_AbortDetect,
    input  logic                  ClrErr,
    output logic [4*NUM_CH-1:0]   ErrPulse,
    output logic [4*NUM_CH-1:0]   ErrSticky,
    output logic [CNT_W-1:0]      ErrCnt,
    output logic [NUM_CH-1:0]     InFrame
);

    localparam int LIMIT = MAX_FRAME_BYTES*8 + 8;
    localparam int BCW   = $clog2(MAX_FRAME_BYTES*8 + 9);
    localparam int SUM_W = CNT_W + 8;

    typedef enum logic [1:0] {HUNT, FRAME, DISCARD} state_t;

    logic [4*NUM_CH-1:0] pulse_d, pulse_q;
    logic [4*NUM_CH-1:0] sticky_d, sticky_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [7:0]     sr_q;
        state_t         state_q, state_d;
        logic [BCW-1:0] bcnt_q, bcnt_d;
        logic [2:0]     ones_q, ones_d;
        logic           flag_d1_q, abort_d1_q;
        logic           flag_m, abort_m, len_ovf;

        assign flag_m  = (sr_q == 8'h7E);
        assign abort_m = (sr_q == 8'h7F);

        // sr_q[0] is the newest bit; it is destuffed and counted while in FRAME
        always_comb begin
            state_d = state_q;
            bcnt_d  = bcnt_q;
            ones_d  = ones_q;
            len_ovf = 1'b0;
            if (flag_m) begin
                state_d = FRAME;
                bcnt_d  = '0;
                ones_d  = '0;
            end else if (abort_m) begin
                state_d = HUNT;
                bcnt_d  = '0;
                ones_d  = '0;
            end else if (state_q == FRAME) begin
                if (bcnt_q == BCW'(LIMIT)) begin
                    len_ovf = 1'b1;
                    state_d = DISCARD;
                end else if (sr_q[0]) begin
                    bcnt_d = bcnt_q + BCW'(1);
                    if (ones_q != 3'd5) begin
                        ones_d = ones_q + 3'd1;
                    end
                end else begin
                    ones_d = '0;
                    if (ones_q != 3'd5) begin
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end
            end
        end

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                sr_q       <= 8'hFF;
                state_q    <= HUNT;
                bcnt_q     <= '0;
                ones_q     <= '0;
                flag_d1_q  <= 1'b0;
                abort_d1_q <= 1'b0;
            end else begin
                sr_q       <= {sr_q[6:0], Rx[ch]};
                state_q    <= state_d;
                bcnt_q     <= bcnt_d;
                ones_q     <= ones_d;
                flag_d1_q  <= flag_m;
                abort_d1_q <= abort_m && (state_q != HUNT);
            end
        end

        assign pulse_d[ch*4+0] = flag_d1_q & ~Rx_FlagDetect[ch];
`ifdef HDLC_CHK_SPURIOUS_EN
        assign pulse_d[ch*4+1] = Rx_FlagDetect[ch] & ~flag_d1_q;
`else
        assign pulse_d[ch*4+1] = 1'b0;
`endif
        assign pulse_d[ch*4+2] = abort_d1_q & ~Rx_AbortDetect[ch];
        assign pulse_d[ch*4+3] = len_ovf;
        assign InFrame[ch]     = (state_q == FRAME);
    end

    // Popcount is summed in a wider field so saturation never loses simultaneous errors
    logic [SUM_W-1:0] pop, total;
    always_comb begin
        pop = '0;
        for (int i = 0; i < 4*NUM_CH; i++) begin
            pop = pop + SUM_W'(pulse_q[i]);
        end
        total = (ClrErr ? '0 : SUM_W'(cnt_q)) + pop;
        if (|total[SUM_W-1:CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = total[CNT_W-1:0];
        end
        sticky_d = ClrErr ? pulse_q : (sticky_q | pulse_q);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pulse_q  <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ErrPulse  = pulse_q;
    assign ErrSticky = sticky_q;
    assign ErrCnt    = cnt_q;

endmodule

// File: tb/tb_hdlc_rx_line_checker.sv
// Directed bench for hdlc_rx_line_checker with NUM_CH=4, CNT_W=2, MAX_FRAME_BYTES=2.
module tb_hdlc_rx_line_checker;

`ifdef HDLC_CHK_SPURIOUS_EN
    localparam logic [15:0] SPUR_EXP = 16'h0002;
`else
    localparam logic [15:0] SPUR_EXP = 16'h0000;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  Rx, Rx_FlagDetect, Rx_AbortDetect;
    logic        ClrErr;
    logic [15:0] ErrPulse, ErrSticky;
    logic [1:0]  ErrCnt;
    logic [3:0]  InFrame;

    int errors = 0;
    int checks = 0;

    logic [7:0] tb_sr [4];
    logic [3:0] pend_f, pend_a, fd_auto, ab_auto, fd_force;

    always #5 Clk = ~Clk;

    hdlc_rx_line_checker #(.NUM_CH(4), .CNT_W(2), .MAX_FRAME_BYTES(2)) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .ClrErr(ClrErr), .ErrPulse(ErrPulse),
        .ErrSticky(ErrSticky), .ErrCnt(ErrCnt), .InFrame(InFrame)
    );

    task automatic model_reset();
        for (int c = 0; c < 4; c++) tb_sr[c] = 8'hFF;
        pend_f = '0; pend_a = '0;
        Rx_FlagDetect = '0; Rx_AbortDetect = '0;
    endtask

    // One bit per channel; a well-behaved Rx block asserts detects two edges after the last pattern bit
    task automatic step(input logic [3:0] b);
        Rx = b;
        @(posedge Clk);
        #1;
        for (int c = 0; c < 4; c++) tb_sr[c] = {tb_sr[c][6:0], b[c]};
        Rx_FlagDetect  = (fd_auto & pend_f) | fd_force;
        Rx_AbortDetect = ab_auto & pend_a;
        for (int c = 0; c < 4; c++) begin
            pend_f[c] = (tb_sr[c] == 8'h7E);
            pend_a[c] = (tb_sr[c] == 8'h7F);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'hF);
    endtask

    task automatic send8(input logic [3:0] mask, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step({4{v[i]}} | ~mask);
    endtask

    task automatic clr();
        idle(12);
        ClrErr = 1'b1;
        step(4'hF);
        ClrErr = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0; Rx = 4'hF; ClrErr = 1'b0;
        fd_auto = 4'hF; ab_auto = 4'hF; fd_force = 4'h0;
        model_reset();
        #23;
        checks++; if (ErrPulse !== 16'h0) begin errors++; $display("FAIL rst_pulse: got %h want %h", ErrPulse, 16'h0); end
        checks++; if (ErrSticky !== 16'h0) begin errors++; $display("FAIL rst_sticky: got %h want %h", ErrSticky, 16'h0); end
        checks++; if (ErrCnt !== 2'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", ErrCnt); end
        checks++; if (InFrame !== 4'h0) begin errors++; $display("FAIL rst_inframe: got %h want 0", InFrame); end
        Rst = 1'b1;
    endtask

    task automatic test_flag_ok();
        logic [7:0] f;
        f = 8'h7E;
        idle(10);
        send8(4'h1, 8'h7E);
        checks++; if (InFrame !== 4'h0) begin errors++; $display("FAIL ok_inframe_early: got %h want 0", InFrame); end
        for (int i = 7; i >= 0; i--) begin
            step({3'b111, f[i]});
            if (i == 7) begin
                checks++; if (InFrame !== 4'h1) begin errors++; $display("FAIL ok_inframe: got %h want 1", InFrame); end
            end
            if (i == 6) begin
                checks++; if (ErrPulse !== 16'h0) begin errors++; $display("FAIL ok_pulse: got %h want 0", ErrPulse); end
            end
        end
        idle(3);
        checks++; if (ErrSticky !== 16'h0) begin errors++; $display("FAIL b2b_sticky: got %h want 0", ErrSticky); end
        checks++; if (InFrame !== 4'h1) begin errors++; $display("FAIL b2b_inframe: got %h want 1", InFrame); end
    endtask

    task automatic test_flag_miss();
        clr();
        fd_auto = 4'h0;
        send8(4'h1, 8'h7E);
        step(4'hF);
        checks++; if (ErrPulse !== 16'h0) begin errors++; $display("FAIL miss_e1: got %h want 0", ErrPulse); end
        step(4'hF);
        checks++; if (ErrPulse !== 16'h0001) begin errors++; $display("FAIL miss_e2: got %h want 0001", ErrPulse); end
        step(4'hF);
        checks++; if (ErrPulse !== 16'h0) begin errors++; $display("FAIL miss_e3_pulse: got %h want 0", ErrPulse); end
        checks++; if (ErrSticky !== 16'h0001) begin errors++; $display("FAIL miss_sticky: got %h want 0001", ErrSticky); end
        checks++; if (ErrCnt !== 2'd1) begin errors++; $display("FAIL miss_cnt: got %0d want 1", ErrCnt); end
        fd_auto = 4'hF;
    endtask

    task automatic test_shared_zero();
        logic [14:0] bits;
        bits = 15'b0111111_0111111_0;
        clr();
        fd_auto = 4'h0;
        for (int i = 14; i >= 0; i--) step({3'b111, bits[i]});
        idle(3);
        checks++; if (ErrCnt !== 2'd2) begin errors++; $display("FAIL shared_cnt: got %0d want 2", ErrCnt); end
        fd_auto = 4'hF;
    endtask

    task automatic test_abort();
        clr();
        send8(4'h1, 8'h7E);
        send8(4'h1, 8'h00);
        ab_auto = 4'h0;
        send8(4'h1, 8'h7F);
        checks++; if (InFrame !== 4'h1) begin errors++; $display("FAIL abort_inframe_pre: got %h want 1", InFrame); end
        step(4'hF);
        checks++; if (InFrame !== 4'h0) begin errors++; $display("FAIL abort_inframe: got %h want 0", InFrame); end
        step(4'hF);
        checks++; if (ErrPulse !== 16'h0004) begin errors++; $display("FAIL abort_pulse: got %h want 0004", ErrPulse); end
        step(4'hF);
        checks++; if (ErrCnt !== 2'd1) begin errors++; $display("FAIL abort_cnt: got %0d want 1", ErrCnt); end
        checks++; if (ErrSticky !== 16'h0004) begin errors++; $display("FAIL abort_sticky: got %h want 0004", ErrSticky); end
        send8(4'h1, 8'h7F);
        step(4'hF);
        step(4'hF);
        checks++; if (ErrPulse !== 16'h0) begin errors++; $display("FAIL abort_hunt_pulse: got %h want 0", ErrPulse); end
        step(4'hF);
        checks++; if (ErrCnt !== 2'd1) begin errors++; $display("FAIL abort_hunt_cnt: got %0d want 1", ErrCnt); end
        ab_auto = 4'hF;
    endtask

    task automatic test_len();
        logic [18:0] stuffed;
        stuffed = 19'b11111_0_11111_0_11111_0_1;
        clr();
        send8(4'h1, 8'h7E);
        for (int i = 18; i >= 0; i--) step({3'b111, stuffed[i]});
        send8(4'h1, 8'h7E);
        idle(2);
        checks++; if (ErrSticky !== 16'h0) begin errors++; $display("FAIL len_ok_sticky: got %h want 0", ErrSticky); end
        checks++; if (InFrame !== 4'h1) begin errors++; $display("FAIL len_ok_inframe: got %h want 1", InFrame); end
        send8(4'h1, 8'h7E);
        for (int k = 1; k <= 26; k++) begin
            step(4'hE);
            if (k == 25) begin
                checks++; if (ErrPulse !== 16'h0 || InFrame !== 4'h1) begin errors++; $display("FAIL len_pre: got pulse %h inframe %h want 0 1", ErrPulse, InFrame); end
            end
        end
        checks++; if (ErrPulse !== 16'h0008) begin errors++; $display("FAIL len_ovf_pulse: got %h want 0008", ErrPulse); end
        checks++; if (InFrame !== 4'h0) begin errors++; $display("FAIL len_discard: got %h want 0", InFrame); end
        for (int k = 0; k < 20; k++) step(4'hE);
        checks++; if (ErrCnt !== 2'd1) begin errors++; $display("FAIL len_once_cnt: got %0d want 1", ErrCnt); end
    endtask

    task automatic test_multi_ch();
        clr();
        fd_auto = 4'h0;
        send8(4'hF, 8'h7E);
        idle(2);
        checks++; if (ErrPulse !== 16'h1111) begin errors++; $display("FAIL multi_pulse: got %h want 1111", ErrPulse); end
        step(4'hF);
        checks++; if (ErrCnt !== 2'd3) begin errors++; $display("FAIL multi_sat: got %0d want 3", ErrCnt); end
        checks++; if (ErrSticky !== 16'h1111) begin errors++; $display("FAIL multi_sticky: got %h want 1111", ErrSticky); end
        idle(10);
        send8(4'h3, 8'h7E);
        idle(2);
        checks++; if (ErrPulse !== 16'h0011) begin errors++; $display("FAIL multi2_pulse: got %h want 0011", ErrPulse); end
        ClrErr = 1'b1;
        step(4'hF);
        ClrErr = 1'b0;
        checks++; if (ErrCnt !== 2'd2) begin errors++; $display("FAIL clr_cnt: got %0d want 2", ErrCnt); end
        checks++; if (ErrSticky !== 16'h0011) begin errors++; $display("FAIL clr_sticky: got %h want 0011", ErrSticky); end
        fd_auto = 4'hF;
    endtask

    task automatic test_spurious();
        clr();
        fd_force = 4'h1;
        step(4'hF);
        fd_force = 4'h0;
        step(4'hF);
        checks++; if (ErrPulse !== SPUR_EXP) begin errors++; $display("FAIL spur_pulse: got %h want %h", ErrPulse, SPUR_EXP); end
        step(4'hF);
        checks++; if (ErrSticky !== SPUR_EXP) begin errors++; $display("FAIL spur_sticky: got %h want %h", ErrSticky, SPUR_EXP); end
    endtask

    task automatic test_reset_midframe();
        clr();
        fd_auto = 4'h0;
        send8(4'h1, 8'h7E);
        idle(3);
        checks++; if (ErrCnt !== 2'd1 || InFrame !== 4'h1) begin errors++; $display("FAIL mid_pre: got cnt %0d inframe %h want 1 1", ErrCnt, InFrame); end
        send8(4'h1, 8'h7E);
        step(4'hF);
        #2 Rst = 1'b0;
        #1;
        checks++; if (ErrSticky !== 16'h0 || ErrCnt !== 2'd0) begin errors++; $display("FAIL mid_rst_err: got sticky %h cnt %0d want 0 0", ErrSticky, ErrCnt); end
        checks++; if (InFrame !== 4'h0 || ErrPulse !== 16'h0) begin errors++; $display("FAIL mid_rst_frame: got inframe %h pulse %h want 0 0", InFrame, ErrPulse); end
        #2 Rst = 1'b1;
        model_reset();
        idle(6);
        checks++; if (ErrCnt !== 2'd0 || ErrSticky !== 16'h0) begin errors++; $display("FAIL mid_after: got cnt %0d sticky %h want 0 0", ErrCnt, ErrSticky); end
        fd_auto = 4'hF;
    endtask

    initial begin
        test_reset();
        test_flag_ok();
        test_flag_miss();
        test_shared_zero();
        test_abort();
        test_len();
        test_multi_ch();
        test_spurious();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_line_checker.md
# hdlc_rx_line_checker

Synthesisable, parametrised protocol checker for the HDLC receive path. It runs alongside the Rx block and replaces simulation-only concurrent assertions with hardware checks. It watches NUM_CH serial lines together with each channel's FlagDetect/AbortDetect outputs, and independently decodes flags, aborts, zero-stuffing and frame length. Mismatches are reported as per-channel error pulses, sticky bits and one saturating error counter, so the same checks run in simulation, emulation and FPGA bring-up.

## Interface
Parameters:
- NUM_CH, 1: number of independent serial channels checked (1..16).
- CNT_W, 16: width of ErrCnt.
- MAX_FRAME_BYTES, 128: maximum destuffed frame payload including FCS, in bytes.

Ports (error vectors indexed ch*4+type; type 0 FLAG_MISS, 1 FLAG_SPUR, 2 ABORT_MISS, 3 LEN_OVF):
- Clk  in  1  one clock for the whole block; all inputs are sampled on its rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Rx  in  NUM_CH  serial line per channel, one bit per Clk.
- Rx_FlagDetect  in  NUM_CH  DUT flag-detect output per channel.
- Rx_AbortDetect  in  NUM_CH  DUT abort-detect output per channel.
- ClrErr  in  1  synchronous clear of ErrCnt and ErrSticky.
- ErrPulse  out  4*NUM_CH  one-cycle error pulses.
- ErrSticky  out  4*NUM_CH  sticky OR of ErrPulse.
- ErrCnt  out  CNT_W  saturating count of all error pulses.
- InFrame  out  NUM_CH  channel FSM is in FRAME.

## Operation
- Per channel, an 8-bit shift register sr={sr[6:0],Rx], oldest bit in the MSB. Reset value 8'hFF.
- Flag match: sr==8'h7E. Abort match: sr==8'h7F. Matches are combinational on the registered sr.
- FSM states: HUNT, FRAME, DISCARD. Reset state is HUNT.
  - A flag match in any state goes to FRAME and clears the bit counter.
  - An abort match goes to HUNT.
  - In FRAME, when the bit counter reaches MAX_FRAME_BYTES*8+8, LEN_OVF pulses and the FSM goes to DISCARD. DISCARD raises no further LEN_OVF.
  - Flag match takes priority over the length limit in the same cycle.
- Destuffing in FRAME:
  - A ones counter (0..5) counts consecutive 1s; a 0 resets it.
  - A 0 received while the counter is 5 is a stuffed bit and is not counted.
  - Every other bit increments the bit counter. The counter includes the first 7 bits of the closing flag, hence the +8 slack.
  - Bit counter width is $clog2(MAX_FRAME_BYTES*8+9).
- Checks (one pipeline flop per match, d1):
  - FLAG_MISS: d1 flag set and Rx_FlagDetect low.
  - FLAG_SPUR: Rx_FlagDetect high and d1 flag clear (feature-gated, see Configuration).
  - ABORT_MISS: d1 abort set, the FSM was not HUNT at match time, and Rx_AbortDetect low.
- ErrCnt:
  - Each cycle it adds the popcount of all ErrPulse bits, saturating at 2^CNT_W-1. It never wraps.
  - When ClrErr is high, ErrCnt loads that cycle's popcount and ErrSticky loads that cycle's ErrPulse. Simultaneous errors are never lost.
- InFrame is high when the FSM is in FRAME.

## Timing
- Rx bit sampled at edge e → sr and match valid in the cycle after e.
- Last flag bit sampled at edge e → Rx_FlagDetect must be sampled high at edge e+2.
- ErrPulse registers at edge e+2 and is high for exactly one cycle. ErrSticky and ErrCnt update at edge e+3.
- Abort uses the same timing, with Rx_AbortDetect sampled at e+2.
- LEN_OVF pulse registers at the edge after the counter reaches its limit.
- Reset values: ErrPulse, ErrSticky, ErrCnt and InFrame are 0; sr is 8'hFF; d1 flops are 0; counters are 0.
- Reset asserted mid-frame: all state clears immediately and checks still in flight in d1 are discarded. After release, no error can fire until at least 8 new bits have been shifted in.
- Back-to-back flags (0x7E7E): each flag is checked independently and the FSM stays in FRAME with count 0.
- A flag sharing a 0 bit (…0111111 0111111 0…) is matched twice.

## Configuration
- HDLC_CHK_SPURIOUS_EN defined: the FLAG_SPUR check is active.
- HDLC_CHK_SPURIOUS_EN undefined: the FLAG_SPUR logic is removed and ErrPulse/ErrSticky bit type 1 are tied to 0 for all channels. Everything else is unchanged, including ErrCnt contribution, which becomes 0 for that type.

## Test plan
- NUM_CH=1; idle 1s, then 0x7E with Rx_FlagDetect driven high two edges after the last bit → no ErrPulse; InFrame=1 from the cycle after the match.
- Same flag with Rx_FlagDetect held low → ErrPulse[0] high one cycle at e+2; ErrSticky[0]=1; ErrCnt=1.
- In FRAME, send 0x7F with Rx_AbortDetect low → ErrPulse[2] pulses and InFrame drops. Repeat in HUNT → no error.
- MAX_FRAME_BYTES=2: frame containing 0xFF 0xFF (stuffed zeros inserted) then a flag → no LEN_OVF. Frame of 3 bytes without a flag → ErrPulse[3] once, state DISCARD, no second pulse.
- NUM_CH=4, CNT_W=2: all four channels miss a flag in the same cycle → ErrCnt=3 (saturated). ClrErr in a cycle with 2 new pulses → ErrCnt=2.
- With the macro defined, pulse Rx_FlagDetect with no flag on the line → ErrPulse[1] pulses. Without the macro → no pulse. Rst asserted mid-frame → all outputs 0 the same cycle.
